// File: rtl/sel_enc_sb.sv
// sel_enc_sb - register select/encode logic with operand busy scoreboard.
//
// Latches the instruction word into an internal IR, decodes the Ra/Rb/Rc
// fields into one-hot register load/drive enables, sign-extends the
// constant field, and tracks which registers have a write in flight so
// the control unit can stall on operand hazards.
//
// Build option:
//   SEL_ENC_R0_ZERO_EN - R0 is hardwired zero: rins[0] is never asserted,
//                        and R0 is never marked busy.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   ir_in, ir_ld          instruction word and its load strobe
//   gra, grb, grc         field select (priority gra > grb > grc)
//   rin, rout, baout      register-in / register-out / base-address-out strobes
//   issue                 mark the Ra register busy
//   wb_valid, wb_idx      writeback completion for register wb_idx
//   rins, routs           one-hot register load / drive enables
//   c_sext                sign-extended constant field
//   ir_q                  current IR contents
//   sel_idx, sel_err      selected register index, multi-select error
//   busy, stall           scoreboard bitmap, operand hazard on current IR
module sel_enc_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int RA_LSB   = 23,
    parameter int RB_LSB   = 19,
    parameter int RC_LSB   = 15,
    parameter int C_W      = 19
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   ir_in,
    input  logic                ir_ld,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic                issue,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [NUM_REGS-1:0] rins,
    output logic [NUM_REGS-1:0] routs,
    output logic [DATA_W-1:0]   c_sext,
    output logic [DATA_W-1:0]   ir_q,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                sel_err,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    if (IDX_W != $clog2(NUM_REGS)) begin : g_bad_idx_w
        $error("sel_enc_sb: IDX_W must equal clog2(NUM_REGS)");
    end

    logic [DATA_W-1:0]   r_ir;
    logic                r_ir_valid;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [IDX_W-1:0]    w_ra, w_rb, w_rc;
    logic                w_any_sel;

    assign w_ra = r_ir[RA_LSB +: IDX_W];
    assign w_rb = r_ir[RB_LSB +: IDX_W];
    assign w_rc = r_ir[RC_LSB +: IDX_W];

    // IR: once loaded it stays valid until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (ir_ld) begin
            r_ir       <= ir_in;
            r_ir_valid <= 1'b1;
        end
    end

    // Scoreboard next state. The set is applied after the clear so that a
    // new write issued to a register whose previous write just retired
    // keeps it busy. issue sees the pre-load IR when ir_ld is also high.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid)
            w_busy_nxt[wb_idx] = 1'b0;
        if (issue)
            w_busy_nxt[w_ra] = 1'b1;
`ifdef SEL_ENC_R0_ZERO_EN
        w_busy_nxt[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Field select. With nothing selected no register is addressed at all
    // (index 0 is reported but all enables stay low).
    assign w_any_sel = gra | grb | grc;
    assign sel_err   = (gra & grb) | (gra & grc) | (grb & grc);

    always_comb begin
        sel_idx = '0;
        if (gra)
            sel_idx = w_ra;
        else if (grb)
            sel_idx = w_rb;
        else if (grc)
            sel_idx = w_rc;
    end

    always_comb begin
        rins  = '0;
        routs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rins[i]  = rin & w_any_sel & (sel_idx == IDX_W'(i));
            routs[i] = (rout | baout) & w_any_sel & (sel_idx == IDX_W'(i));
        end
        // R0 reads as zero on the bus in base-address mode
        if (baout && sel_idx == '0)
            routs = '0;
`ifdef SEL_ENC_R0_ZERO_EN
        rins[0] = 1'b0;
`endif
    end

    assign c_sext = {{(DATA_W-C_W){r_ir[C_W-1]}}, r_ir[C_W-1:0]};
    assign ir_q   = r_ir;
    assign busy   = r_busy;
    assign stall  = r_ir_valid & (r_busy[w_rb] | r_busy[w_rc]);

endmodule

// File: tb/tb_sel_enc_sb.sv
// Directed self-checking bench for sel_enc_sb (default parameters).
// Expectations that depend on SEL_ENC_R0_ZERO_EN are selected by the same macro.
module tb_sel_enc_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_in;
    logic        ir_ld, gra, grb, grc, rin, rout, baout, issue, wb_valid;
    logic [3:0]  wb_idx;
    logic [15:0] rins, routs, busy;
    logic [31:0] c_sext, ir_q;
    logic [3:0]  sel_idx;
    logic        sel_err, stall;

    int n_chk  = 0;
    int n_fail = 0;

    sel_enc_sb dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ir_ld(ir_ld),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .issue(issue), .wb_valid(wb_valid), .wb_idx(wb_idx),
        .rins(rins), .routs(routs), .c_sext(c_sext), .ir_q(ir_q),
        .sel_idx(sel_idx), .sel_err(sel_err), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] v);
        ir_in = v; ir_ld = 1'b1;
        tick();
        ir_ld = 1'b0;
    endtask

    task automatic clr_sel();
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    endtask

    initial begin
        reset = 1'b1; ir_in = '0; ir_ld = 0; issue = 0; wb_valid = 0; wb_idx = '0;
        clr_sel();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_ir_q",  ir_q,   32'h0);
        chk("rst_busy",  busy,   32'h0);
        chk("rst_stall", stall,  32'h0);
        chk("rst_csext", c_sext, 32'h0);
        chk("rst_rins",  rins,   32'h0);
        chk("rst_routs", routs,  32'h0);
        chk("rst_sel",   {sel_err, sel_idx}, 32'h0);

        // decode: ra=4 rb=5 rc=9, C=19'h48005
        load_ir(32'h0A2C_8005);
        chk("ir_load",   ir_q,   32'h0A2C_8005);
        chk("csext_neg0", c_sext, 32'hFFFC_8005);
        gra = 1; rin = 1; #1;
        chk("gra_idx",   sel_idx, 32'd4);
        chk("gra_rins",  rins,    32'h0010);
        chk("gra_routs", routs,   32'h0000);
        clr_sel(); grb = 1; rout = 1; #1;
        chk("grb_idx",   sel_idx, 32'd5);
        chk("grb_routs", routs,   32'h0020);
        chk("grb_rins",  rins,    32'h0000);
        clr_sel(); grc = 1; rout = 1; #1;
        chk("grc_routs", routs,   32'h0200);
        clr_sel(); gra = 1; grc = 1; #1;
        chk("multi_err", sel_err, 32'd1);
        chk("multi_idx", sel_idx, 32'd4);
        clr_sel(); rin = 1; #1;
        chk("nosel_rins", rins,   32'h0000);
        chk("nosel_idx",  sel_idx, 32'd0);
        chk("nosel_err",  sel_err, 32'd0);
        clr_sel();

        // sign extension boundaries
        load_ir(32'h0004_0001);
        chk("csext_neg", c_sext, 32'hFFFC_0001);
        load_ir(32'h0000_0FFF);
        chk("csext_pos", c_sext, 32'h0000_0FFF);

        // scoreboard: RAW hazard on rb
        load_ir(32'h0280_0000);                  // ra=5 rb=0 rc=0
        issue = 1; tick(); issue = 0;
        chk("sb_set",    busy,  32'h0020);
        chk("sb_nohaz",  stall, 32'd0);
        load_ir(32'h0028_0000);                  // rb=5
        chk("sb_stall",  stall, 32'd1);
        wb_valid = 1; wb_idx = 4'd5; #1;
        chk("sb_stall_pre_edge", stall, 32'd1);
        tick(); wb_valid = 0;
        chk("sb_clr_stall", stall, 32'd0);
        chk("sb_clr_busy",  busy,  32'h0000);

        // set and clear of the same index in one cycle: set wins
        load_ir(32'h0280_0000);                  // ra=5
        issue = 1; wb_valid = 1; wb_idx = 4'd5;
        tick(); issue = 0; wb_valid = 0;
        chk("sb_setwins", busy, 32'h0020);
        // different indices in one cycle: both apply
        load_ir(32'h0180_0000);                  // ra=3
        issue = 1; wb_valid = 1; wb_idx = 4'd5;
        tick(); issue = 0; wb_valid = 0;
        chk("sb_both",   busy, 32'h0008);
        // writeback to a non-busy register
        wb_valid = 1; wb_idx = 4'd7; tick(); wb_valid = 0;
        chk("sb_wb_idle", busy, 32'h0008);
        // ir_ld with issue: issue uses the old IR (ra=3)
        wb_valid = 1; wb_idx = 4'd3; tick(); wb_valid = 0;
        ir_in = 32'h0280_0000; ir_ld = 1; issue = 1;
        tick(); ir_ld = 0; issue = 0;
        chk("sb_old_ir", busy, 32'h0008);
        chk("sb_new_ir", ir_q, 32'h0280_0000);
        wb_valid = 1; wb_idx = 4'd3; tick(); wb_valid = 0;

        // R0 handling: ra=0 rb=5 rc=0
        load_ir(32'h0028_0000);
        gra = 1; baout = 1; #1;
        chk("ba_r0_routs", routs, 32'h0000);
        clr_sel(); grb = 1; baout = 1; #1;
        chk("ba_r5_routs", routs, 32'h0020);
        clr_sel(); gra = 1; rin = 1; #1;
`ifdef SEL_ENC_R0_ZERO_EN
        chk("r0_rins", rins, 32'h0000);
`else
        chk("r0_rins", rins, 32'h0001);
`endif
        clr_sel();
        issue = 1; tick(); issue = 0;
`ifdef SEL_ENC_R0_ZERO_EN
        chk("r0_busy",  busy,  32'h0000);
        chk("r0_stall", stall, 32'd0);
`else
        chk("r0_busy",  busy,  32'h0001);
        chk("r0_stall", stall, 32'd1);       // rc=0 is busy
`endif
        wb_valid = 1; wb_idx = 4'd0; tick(); wb_valid = 0;
        chk("r0_clear", busy, 32'h0000);

        // build busy=0x00F0, then reset asynchronously mid-cycle
        for (int r = 4; r < 8; r++) begin
            load_ir((32'(r) << 23) | (32'd5 << 19));
            issue = 1; tick(); issue = 0;
        end
        chk("pre_rst_busy",  busy,  32'h00F0);
        chk("pre_rst_stall", stall, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy",  busy,   32'h0000);
        chk("async_ir_q",  ir_q,   32'h0000_0000);
        chk("async_stall", stall,  32'd0);
        chk("async_csext", c_sext, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
